// File: rtl/matrix_stream_generator.sv
// matrix_stream_generator
// Streams one DIM x DIM matrix out of a built-in ROM over a valid/ready
// handshake, either row by row (A operand) or column by column (B operand).
// The ROM is a ramp: word i holds i truncated to DATA_W bits. Matrix m
// occupies words m*DIM*DIM .. m*DIM*DIM+DIM*DIM-1, and element (row, col)
// of a matrix sits at offset row*DIM+col.
module matrix_stream_generator #(
  parameter int DATA_W  = 8,
  parameter int DIM     = 4,
  parameter int NUM_MAT = 6
) (
  input  logic                                             i_clk,
  input  logic                                             i_rst,
  input  logic                                             i_data_request,
  input  logic [((NUM_MAT > 1) ? $clog2(NUM_MAT) : 1)-1:0] i_mat_sel,
  input  logic                                             i_col_major,
  output logic signed [DATA_W-1:0]                         o_dout,
  output logic                                             o_dout_valid,
  input  logic                                             i_dout_ready,
  output logic                                             o_dout_last,
  output logic                                             o_busy,
  output logic                                             o_done,
  output logic                                             o_err
);

  localparam int SEL_W  = (NUM_MAT > 1) ? $clog2(NUM_MAT) : 1;
  localparam int CNT_W  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int ADDR_W = (NUM_MAT * DIM * DIM > 1) ? $clog2(NUM_MAT * DIM * DIM) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DIM - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [SEL_W:0]    SEL_LIMIT = (SEL_W + 1)'(NUM_MAT);
  localparam logic [ADDR_W-1:0] MAT_SIZE  = ADDR_W'(DIM * DIM);
  localparam logic [ADDR_W-1:0] DIM_A     = ADDR_W'(DIM);
  localparam logic              ONE_ELEM  = (DIM == 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        r_state;
  logic [SEL_W-1:0]  r_sel;
  logic              r_col_major;
  logic [CNT_W-1:0]  r_row;
  logic [CNT_W-1:0]  r_col;
  logic [DATA_W-1:0] r_dout;
  logic              r_valid;
  logic              r_last;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_sel_ok;
  logic              w_xfer;
  logic [CNT_W-1:0]  w_row_next;
  logic [CNT_W-1:0]  w_col_next;
  logic              w_last_next;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_rom_data;

  // ROM contents: each word holds its own address.
  function automatic logic [DATA_W-1:0] romWord(input logic [ADDR_W-1:0] addr);
    return DATA_W'(addr);
  endfunction

  assign w_sel_ok    = ({1'b0, i_mat_sel} < SEL_LIMIT);
  assign w_xfer      = r_valid && i_dout_ready;
  assign w_last_next = (w_row_next == CNT_MAX) && (w_col_next == CNT_MAX);
  assign w_rom_data  = romWord(w_addr);

  // Advance the element position: column index fastest in row-major order,
  // row index fastest in column-major order (walking down one column).
  always_comb begin
    w_row_next = r_row;
    w_col_next = r_col;
    if (r_col_major) begin
      if (r_row == CNT_MAX) begin
        w_row_next = '0;
        w_col_next = r_col + CNT_ONE;
      end else begin
        w_row_next = r_row + CNT_ONE;
      end
    end else begin
      if (r_col == CNT_MAX) begin
        w_col_next = '0;
        w_row_next = r_row + CNT_ONE;
      end else begin
        w_col_next = r_col + CNT_ONE;
      end
    end
  end

  // ROM address: element 0 of the requested matrix while idle, otherwise the
  // element that follows the one currently on the output.
  always_comb begin
    w_addr = '0;
    if (r_state == S_IDLE) begin
      w_addr = ADDR_W'(i_mat_sel) * MAT_SIZE;
    end else begin
      w_addr = ADDR_W'(r_sel) * MAT_SIZE + ADDR_W'(w_row_next) * DIM_A + ADDR_W'(w_col_next);
    end
  end

  // Request acceptance, registered ROM read, handshake and completion control.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_col_major <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_data_request) begin
            if (w_sel_ok) begin
              r_state     <= S_STREAM;
              r_sel       <= i_mat_sel;
              r_col_major <= i_col_major;
              r_row       <= '0;
              r_col       <= '0;
              r_dout      <= w_rom_data;
              r_valid     <= 1'b1;
              r_last      <= ONE_ELEM;
              r_busy      <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (r_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_row   <= '0;
              r_col   <= '0;
            end else begin
              r_row  <= w_row_next;
              r_col  <= w_col_next;
              r_dout <= w_rom_data;
              r_last <= w_last_next;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_sel       <= '0;
          r_col_major <= 1'b0;
          r_row       <= '0;
          r_col       <= '0;
          r_dout      <= '0;
          r_valid     <= 1'b0;
          r_last      <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_err       <= 1'b0;
        end
      endcase
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_valid;
  assign o_dout_last  = r_last;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule
